// File: rtl/mpmem_pkg.sv
// Shared types and helpers for the banked multi-port memory.
package mpmem_pkg;

    // Wide enough for any practical bank count; unused upper bits stay zero.
    localparam int unsigned TAG_BANK_W = 16;

    // One stage of the per-port read pipeline: is a read in flight, and from which bank.
    typedef struct packed {
        logic                  valid;
        logic [TAG_BANK_W-1:0] bank;
    } rd_tag_t;

    // Number of address bits used to select a bank (0 for a single bank).
    function automatic int unsigned calc_bank_bits(input int unsigned banks);
        return (banks > 1) ? int'($clog2(banks)) : 0;
    endfunction

    // Bank index of a word address: its low bank_bits bits.
    function automatic int unsigned bank_of(input logic [31:0] addr, input int unsigned bank_bits);
        logic [31:0] mask;
        mask = (32'd1 << bank_bits) - 32'd1;
        return int'(addr & mask);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating pointer and a one-hot grant.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  grant_raw;
    logic          found;
    int            idx;

    // Pick the first requester at or after the pointer, wrapping; advance the pointer past it.
    always_comb begin
        grant_raw = '0;
        ptr_d     = ptr_q;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                grant_raw[idx] = 1'b1;
                found          = 1'b1;
                ptr_d          = PW'((idx + 1) % N);
            end
        end
        grant = grant_raw & {N{rst}};
    end

    // Pointer register; returns to port 0 on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/banked_multiport_memory.sv
// Multi-port RAM built from independent banks, each with its own read and write arbiter.
module banked_multiport_memory
    import mpmem_pkg::*;
#(
    parameter int READ_PORTS  = 3,
    parameter int WRITE_PORTS = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int BANKS       = 4,
    parameter int DATA_LAT    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] r_addr,
    input  logic [READ_PORTS-1:0]                 r_avalid,
    output logic [READ_PORTS-1:0]                 r_aready,
    output logic [READ_PORTS-1:0]                 r_dvalid,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] r_data,
    input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] w_addr,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] w_data,
    input  logic [WRITE_PORTS-1:0]                w_valid,
    output logic [WRITE_PORTS-1:0]                w_ready
);

    localparam int unsigned BANK_BITS = calc_bank_bits(BANKS);
    localparam int unsigned ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int unsigned RW        = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int unsigned ROWS      = 1 << ROW_BITS;

    logic [BANKS-1:0][READ_PORTS-1:0]  rd_req;
    logic [BANKS-1:0][READ_PORTS-1:0]  rd_gnt;
    logic [BANKS-1:0][WRITE_PORTS-1:0] wr_req;
    logic [BANKS-1:0][WRITE_PORTS-1:0] wr_gnt;
    logic [BANKS-1:0]                  rd_en;
    logic [BANKS-1:0]                  wr_en;
    logic [BANKS-1:0][RW-1:0]          rd_row;
    logic [BANKS-1:0][RW-1:0]          wr_row;
    logic [BANKS-1:0][DATA_WIDTH-1:0]  wr_dat;
    logic [BANKS-1:0][DATA_WIDTH-1:0]  bank_out;

    rd_tag_t tag_q [READ_PORTS][DATA_LAT];
    rd_tag_t tag_d [READ_PORTS][DATA_LAT];

    // Route every valid request to the arbiter of the bank its address falls in.
    always_comb begin
        rd_req = '0;
        wr_req = '0;
        for (int b = 0; b < BANKS; b++) begin
            for (int p = 0; p < READ_PORTS; p++) begin
                rd_req[b][p] = r_avalid[p] &&
                    (bank_of(32'(r_addr[p]), BANK_BITS) == int'(b));
            end
            for (int p = 0; p < WRITE_PORTS; p++) begin
                wr_req[b][p] = w_valid[p] &&
                    (bank_of(32'(w_addr[p]), BANK_BITS) == int'(b));
            end
        end
    end

    // A port only ever requests one bank, so its ready is the OR of that port's grants.
    always_comb begin
        r_aready = '0;
        w_ready  = '0;
        for (int b = 0; b < BANKS; b++) begin
            r_aready = r_aready | rd_gnt[b];
            w_ready  = w_ready  | wr_gnt[b];
        end
    end

    // Per bank, steer the granted port's row and data to the storage.
    always_comb begin
        rd_en  = '0;
        wr_en  = '0;
        rd_row = '0;
        wr_row = '0;
        wr_dat = '0;
        for (int b = 0; b < BANKS; b++) begin
            rd_en[b] = |rd_gnt[b];
            wr_en[b] = |wr_gnt[b];
            for (int p = 0; p < READ_PORTS; p++) begin
                if (rd_gnt[b][p]) begin
                    rd_row[b] = RW'(32'(r_addr[p]) >> BANK_BITS);
                end
            end
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (wr_gnt[b][p]) begin
                    wr_row[b] = RW'(32'(w_addr[p]) >> BANK_BITS);
                    wr_dat[b] = w_data[p];
                end
            end
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic [DATA_WIDTH-1:0]                mem [ROWS];
        logic [DATA_LAT-1:0][DATA_WIDTH-1:0]  dstage_q;
        logic [DATA_LAT-1:0][DATA_WIDTH-1:0]  dstage_d;

        rr_arbiter #(.N(READ_PORTS)) u_rd_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (rd_req[g]),
            .grant (rd_gnt[g])
        );

        rr_arbiter #(.N(WRITE_PORTS)) u_wr_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (wr_req[g]),
            .grant (wr_gnt[g])
        );

        // Storage write; contents survive reset, and grants are already blocked during reset.
        always_ff @(posedge clk) begin
            if (wr_en[g]) begin
                mem[wr_row[g]] <= wr_dat[g];
            end
        end

        // Registered read of the old contents (read-first), then shift through the latency stages.
        always_comb begin
            dstage_d = dstage_q;
            if (rd_en[g]) begin
                dstage_d[0] = mem[rd_row[g]];
            end
            for (int k = 1; k < DATA_LAT; k++) begin
                dstage_d[k] = dstage_q[k-1];
            end
        end

        // Read data pipeline registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dstage_q <= '0;
            end else begin
                dstage_q <= dstage_d;
            end
        end

        assign bank_out[g] = dstage_q[DATA_LAT-1];
    end

    // Each port tracks its in-flight reads and their source bank in step with the bank data pipeline.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            tag_d[p][0].valid = r_avalid[p] & r_aready[p];
            tag_d[p][0].bank  = TAG_BANK_W'(bank_of(32'(r_addr[p]), BANK_BITS));
            for (int k = 1; k < DATA_LAT; k++) begin
                tag_d[p][k] = tag_q[p][k-1];
            end
        end
    end

    // Tag registers; reset discards all in-flight reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < READ_PORTS; p++) begin
                for (int k = 0; k < DATA_LAT; k++) begin
                    tag_q[p][k] <= '0;
                end
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    // Return data to each port from the bank its oldest tag names; zero when nothing is valid.
    always_comb begin
        r_dvalid = '0;
        r_data   = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (tag_q[p][DATA_LAT-1].valid) begin
                r_dvalid[p] = 1'b1;
                for (int b = 0; b < BANKS; b++) begin
                    if (tag_q[p][DATA_LAT-1].bank == TAG_BANK_W'(b)) begin
                        r_data[p] = bank_out[b];
                    end
                end
            end
        end
    end

endmodule
